// File: rtl/pixel_line_packetizer.sv
// pixel_line_packetizer
// Turns a packed RGB888 pixel stream (4 bytes per word, one frame framed by
// SOP/EOP) into one DSI long packet per image line:
//   header  {ECC, WC[15:8], WC[7:0], VC, DATA_TYPE}   (SOP, empty=0)
//   payload IMG_WIDTH*3/4 words, passed through unchanged
//   footer  {16'h0000, CRC-16}                         (EOP, empty=2)
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   st_in_data/valid/sop/eop/ready    input pixel stream (ready/valid)
//   st_out_data/valid/sop/eop/empty   output packet stream, one register stage
//   st_out_ready                      downstream accept
//   frame_start                       one-cycle pulse with the header of line 0
//   sync_err                          sticky framing error, cleared by reset only
module pixel_line_packetizer #(
    parameter int unsigned IMG_WIDTH = 64,
    parameter int unsigned IMG_HEIGH = 24,
    parameter logic [5:0]  DATA_TYPE = 6'h3E,
    parameter logic [1:0]  VC        = 2'b00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] st_in_data,
    input  logic        st_in_valid,
    input  logic        st_in_startofpacket,
    input  logic        st_in_endofpacket,
    output logic        st_in_ready,
    output logic [31:0] st_out_data,
    output logic        st_out_valid,
    output logic        st_out_startofpacket,
    output logic        st_out_endofpacket,
    output logic [1:0]  st_out_empty,
    input  logic        st_out_ready,
    output logic        frame_start,
    output logic        sync_err
);

    // DSI v1.1 header ECC: 6 Hamming parity bits over the 24-bit header.
    function automatic logic [5:0] ecc_f(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^ d[13] ^
               d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^ d[14] ^
               d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^ d[15] ^
               d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^ d[15] ^
               d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^ d[18] ^
               d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^
               d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    // Reflected CRC-16 (0x8408), one bit at a time starting from bit 0, so
    // byte 0 is absorbed first and each byte LSB-first.
    function automatic logic [15:0] crc_word_f(input logic [15:0] crc_in, input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 32; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[15:1]};
            if (fb) begin
                c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    localparam int unsigned    WPL         = IMG_WIDTH * 3 / 4;
    localparam int unsigned    WCW         = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned    LCW         = (IMG_HEIGH > 1) ? $clog2(IMG_HEIGH) : 1;
    localparam logic [WCW-1:0] WORD_LAST   = WCW'(WPL - 1);
    localparam logic [LCW-1:0] LINE_LAST   = LCW'(IMG_HEIGH - 1);
    localparam logic [WCW-1:0] WORD_ZERO   = WCW'(0);
    localparam logic [LCW-1:0] LINE_ZERO   = LCW'(0);
    localparam logic [WCW-1:0] WORD_ONE    = WCW'(1);
    localparam logic [LCW-1:0] LINE_ONE    = LCW'(1);
    localparam logic [15:0]    WC          = 16'(IMG_WIDTH * 3);
    localparam logic [7:0]     ECC         = {2'b00, ecc_f({WC, VC, DATA_TYPE})};
    localparam logic [31:0]    HEADER_WORD = {ECC, WC[15:8], WC[7:0], VC, DATA_TYPE};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_FOOTER  = 2'd3
    } state_t;

    state_t         state_r,       state_s;
    logic [WCW-1:0] word_cnt_r,    word_cnt_s;
    logic [LCW-1:0] line_cnt_r,    line_cnt_s;
    logic [15:0]    crc_r,         crc_s;
    logic           out_valid_r,   out_valid_s;
    logic [31:0]    out_data_r,    out_data_s;
    logic           out_sop_r,     out_sop_s;
    logic           out_eop_r,     out_eop_s;
    logic [1:0]     out_empty_r,   out_empty_s;
    logic           frame_start_r, frame_start_s;
    logic           sync_err_r,    sync_err_s;
    logic           in_en_r;
    logic           load_s;
    logic           bad_pos_s;
    logic           in_ready_s;
    logic           in_xfer_s;

    // Input acceptance: output-stage load condition plus SOP lookahead so a
    // frame-start word is left on the input until the header has gone out.
    always_comb begin
        load_s     = ~out_valid_r | st_out_ready;
        bad_pos_s  = (word_cnt_r != WORD_ZERO) | (line_cnt_r != LINE_ZERO);
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:    in_ready_s = in_en_r & ~(st_in_valid & st_in_startofpacket);
            ST_PAYLOAD: in_ready_s = in_en_r & load_s &
                                     ~(st_in_valid & st_in_startofpacket & bad_pos_s);
            default:    in_ready_s = 1'b0;
        endcase
        in_xfer_s = st_in_valid & in_ready_s;
    end

    // Next-state, counter, CRC and output-register values.
    always_comb begin
        state_s       = state_r;
        word_cnt_s    = word_cnt_r;
        line_cnt_s    = line_cnt_r;
        crc_s         = crc_r;
        out_data_s    = out_data_r;
        out_sop_s     = out_sop_r;
        out_eop_s     = out_eop_r;
        out_empty_s   = out_empty_r;
        frame_start_s = 1'b0;
        sync_err_s    = sync_err_r;
        // A consumed word leaves the register empty unless refilled below;
        // a stalled word keeps every qualifier untouched.
        if (load_s) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (in_en_r & st_in_valid & st_in_startofpacket) begin
                    state_s    = ST_HEADER;
                    line_cnt_s = LINE_ZERO;
                end else if (in_xfer_s) begin
                    // Word outside a frame: dropped.
                    sync_err_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HEADER: begin
                if (load_s) begin
                    out_valid_s   = 1'b1;
                    out_data_s    = HEADER_WORD;
                    out_sop_s     = 1'b1;
                    out_eop_s     = 1'b0;
                    out_empty_s   = 2'd0;
                    frame_start_s = (line_cnt_r == LINE_ZERO);
                    word_cnt_s    = WORD_ZERO;
                    crc_s         = 16'hFFFF;
                    state_s       = ST_PAYLOAD;
                end else begin
                    state_s = ST_HEADER;
                end
            end

            ST_PAYLOAD: begin
                if (st_in_valid & st_in_startofpacket & bad_pos_s) begin
                    // Unexpected new frame: drop this line without a footer;
                    // the SOP word stays on the input for IDLE to pick up.
                    sync_err_s = 1'b1;
                    state_s    = ST_IDLE;
                end else if (in_xfer_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = st_in_data;
                    out_sop_s   = 1'b0;
                    out_eop_s   = 1'b0;
                    out_empty_s = 2'd0;
                    crc_s       = crc_word_f(crc_r, st_in_data);
                    if (st_in_endofpacket &
                        ~((word_cnt_r == WORD_LAST) & (line_cnt_r == LINE_LAST))) begin
                        sync_err_s = 1'b1;
                    end else begin
                        sync_err_s = sync_err_r;
                    end
                    if (word_cnt_r == WORD_LAST) begin
                        state_s = ST_FOOTER;
                    end else begin
                        word_cnt_s = word_cnt_r + WORD_ONE;
                    end
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end

            ST_FOOTER: begin
                if (load_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = {16'h0000, crc_r};
                    out_sop_s   = 1'b0;
                    out_eop_s   = 1'b1;
                    out_empty_s = 2'd2;
                    if (line_cnt_r == LINE_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        line_cnt_s = line_cnt_r + LINE_ONE;
                        state_s    = ST_HEADER;
                    end
                end else begin
                    state_s = ST_FOOTER;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, CRC and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            word_cnt_r    <= WORD_ZERO;
            line_cnt_r    <= LINE_ZERO;
            crc_r         <= 16'hFFFF;
            out_valid_r   <= 1'b0;
            out_data_r    <= 32'h0000_0000;
            out_sop_r     <= 1'b0;
            out_eop_r     <= 1'b0;
            out_empty_r   <= 2'd0;
            frame_start_r <= 1'b0;
            sync_err_r    <= 1'b0;
            in_en_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            word_cnt_r    <= word_cnt_s;
            line_cnt_r    <= line_cnt_s;
            crc_r         <= crc_s;
            out_valid_r   <= out_valid_s;
            out_data_r    <= out_data_s;
            out_sop_r     <= out_sop_s;
            out_eop_r     <= out_eop_s;
            out_empty_r   <= out_empty_s;
            frame_start_r <= frame_start_s;
            sync_err_r    <= sync_err_s;
            in_en_r       <= 1'b1;
        end
    end

    assign st_in_ready          = in_ready_s;
    assign st_out_data          = out_data_r;
    assign st_out_valid         = out_valid_r;
    assign st_out_startofpacket = out_sop_r;
    assign st_out_endofpacket   = out_eop_r;
    assign st_out_empty         = out_empty_r;
    assign frame_start          = frame_start_r;
    assign sync_err             = sync_err_r;

endmodule

// File: tb/tb_pixel_line_packetizer.sv
// Scoreboard bench for pixel_line_packetizer: the stimulus side pushes every
// expected output word {sop, eop, empty, data} when it issues the input that
// causes it; a monitor pops and compares on each output handshake.
module tb_pixel_line_packetizer;

    localparam int          H   = 24;
    localparam int          WPL = 48;
    localparam int          TMO = 4000;
    localparam logic [31:0] HDR = 32'h0800_C03E;

    logic        clk;
    logic        rst_n;
    logic [31:0] st_in_data;
    logic        st_in_valid;
    logic        st_in_startofpacket;
    logic        st_in_endofpacket;
    logic        st_in_ready;
    logic [31:0] st_out_data;
    logic        st_out_valid;
    logic        st_out_startofpacket;
    logic        st_out_endofpacket;
    logic [1:0]  st_out_empty;
    logic        st_out_ready;
    logic        frame_start;
    logic        sync_err;

    logic [35:0] sb[$];
    int          checks  = 0;
    int          errors  = 0;
    int          fs_cnt  = 0;
    int          sop_cnt = 0;
    int          eop_cnt = 0;
    bit          rand_en = 1'b0;

    pixel_line_packetizer #(
        .IMG_WIDTH(64),
        .IMG_HEIGH(24),
        .DATA_TYPE(6'h3E),
        .VC(2'b00)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .st_in_data          (st_in_data),
        .st_in_valid         (st_in_valid),
        .st_in_startofpacket (st_in_startofpacket),
        .st_in_endofpacket   (st_in_endofpacket),
        .st_in_ready         (st_in_ready),
        .st_out_data         (st_out_data),
        .st_out_valid        (st_out_valid),
        .st_out_startofpacket(st_out_startofpacket),
        .st_out_endofpacket  (st_out_endofpacket),
        .st_out_empty        (st_out_empty),
        .st_out_ready        (st_out_ready),
        .frame_start         (frame_start),
        .sync_err            (sync_err)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: constant 1 or a 50% coin flip each cycle.
    initial begin
        st_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            st_out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Byte-wise reflected CRC-16/0x8408 reference.
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [31:0] d);
        logic [15:0] c;
        logic [7:0]  b;
        c = c_in;
        for (int k = 0; k < 4; k++) begin
            b = d[8*k +: 8];
            c = c ^ {8'h00, b};
            for (int j = 0; j < 8; j++) begin
                if (c[0]) c = (c >> 1) ^ 16'h8408;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    // Monitor: compare each transferred word, and check stall stability.
    logic [35:0] mon_cur;
    logic [36:0] mon_prev;
    logic [35:0] mon_exp;
    bit          mon_stall;
    initial begin
        mon_stall = 1'b0;
        mon_prev  = '0;
        forever begin
            @(negedge clk);
            mon_cur = {st_out_startofpacket, st_out_endofpacket, st_out_empty, st_out_data};
            if (!rst_n) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) chk("stall_hold", {3'b000, st_out_valid, mon_cur}, {3'b000, mon_prev});
                if (st_out_valid && st_out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=%h required=none", mon_cur);
                    end else begin
                        mon_exp = sb.pop_front();
                        chk("out_word", {4'h0, mon_cur}, {4'h0, mon_exp});
                    end
                    if (st_out_startofpacket) sop_cnt++;
                    if (st_out_endofpacket)   eop_cnt++;
                end
                if (frame_start) fs_cnt++;
                mon_stall = st_out_valid && !st_out_ready;
                mon_prev  = {st_out_valid, mon_cur};
            end
        end
    end

    // Present one input word until accepted (bounded).
    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
        int waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        st_in_data          = d;
        st_in_startofpacket = sop;
        st_in_endofpacket   = eop;
        st_in_valid         = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (st_in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > TMO) begin
                checks++;
                errors++;
                $display("FAIL in_accept_timeout actual=%0d required<=%0d", waited, TMO);
                done = 1'b1;
            end
        end
        st_in_valid         = 1'b0;
        st_in_startofpacket = 1'b0;
        st_in_endofpacket   = 1'b0;
    endtask

    // Drive one frame; stop_line/stop_word >= 0 cuts it before that word.
    task automatic send_frame(input logic [7:0] tag, input bit all_ff,
                              input int stop_line, input int stop_word);
        logic [15:0] crc;
        logic [31:0] d;
        for (int l = 0; l < H; l++) begin
            sb.push_back({1'b1, 1'b0, 2'd0, HDR});
            crc = 16'hFFFF;
            for (int w = 0; w < WPL; w++) begin
                if (l == stop_line && w == stop_word) return;
                d = all_ff ? 32'hFFFF_FFFF : {tag, 8'(l), 8'(w), 8'hA5 ^ 8'(l + w)};
                sb.push_back({1'b0, 1'b0, 2'd0, d});
                crc = crc_model(crc, d);
                send_word(d, (l == 0 && w == 0), (l == H - 1 && w == WPL - 1));
            end
            sb.push_back({1'b0, 1'b1, 2'd2, 16'h0000, crc});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || st_out_valid) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("drain_left", 40'(sb.size()), 40'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic end_test(input string name, input int e_sop, input int e_eop,
                            input int e_fs, input logic e_err);
        drain();
        chk({name, "_sop_count"},   40'(sop_cnt), 40'(e_sop));
        chk({name, "_eop_count"},   40'(eop_cnt), 40'(e_eop));
        chk({name, "_frame_start"}, 40'(fs_cnt),  40'(e_fs));
        chk({name, "_sync_err"},    {39'd0, sync_err}, {39'd0, e_err});
        sop_cnt = 0;
        eop_cnt = 0;
        fs_cnt  = 0;
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_out_valid"}, {39'd0, st_out_valid}, 40'd0);
        chk({name, "_out_data"},  {8'd0, st_out_data},   40'd0);
        chk({name, "_out_qual"},  {36'd0, st_out_startofpacket, st_out_endofpacket, st_out_empty}, 40'd0);
        chk({name, "_flags"},     {37'd0, frame_start, sync_err, st_in_ready}, 40'd0);
    endtask

    // Watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        rst_n               = 1'b0;
        st_in_data          = 32'h0;
        st_in_valid         = 1'b0;
        st_in_startofpacket = 1'b0;
        st_in_endofpacket   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-0xFF frame, no backpressure.
        send_frame(8'h00, 1'b1, -1, 0);
        end_test("ff_frame", 24, 24, 1, 1'b0);

        // Same frame under random backpressure.
        rand_en = 1'b1;
        send_frame(8'h00, 1'b1, -1, 0);
        end_test("ff_stall", 24, 24, 1, 1'b0);
        rand_en = 1'b0;

        // Two frames with no gap.
        send_frame(8'h11, 1'b0, -1, 0);
        send_frame(8'h22, 1'b0, -1, 0);
        end_test("b2b", 48, 48, 2, 1'b0);

        // Stray words before a frame.
        send_word(32'h1234_5678, 1'b0, 1'b0);
        send_word(32'h9ABC_DEF0, 1'b0, 1'b1);
        send_word(32'h0F0F_0F0F, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("stray_sync_err_now", {39'd0, sync_err}, 40'd1);
        @(posedge clk);
        #1;
        send_frame(8'h33, 1'b0, -1, 0);
        end_test("stray", 24, 24, 1, 1'b1);

        // New SOP at payload word 10 of line 5, with backpressure.
        rand_en = 1'b1;
        send_frame(8'h44, 1'b0, 5, 10);
        send_frame(8'h55, 1'b0, -1, 0);
        end_test("sop_inject", 30, 29, 2, 1'b1);
        rand_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset pulse during payload of line 2.
        send_frame(8'h66, 1'b0, 2, 20);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("mid_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        sop_cnt = 0;
        eop_cnt = 0;
        fs_cnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(8'h77, 1'b0, -1, 0);
        end_test("post_reset", 24, 24, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
